xalu_ctrl: RTL and testbench

Multi-cycle controller for the multiply/divide unit (XALU) and its HI/LO registers in the 5-stage pipelined MIPS core. It accepts a start pulse from the E stage, latches operands, and holds `busy` for a fixed operation latency. It commits results to HI/LO and serves MFHI/MFLO reads. It raises `stall_req` so the hazard unit freezes any XALU instruction in D while the unit is occupied.

---
 rtl/xalu_ctrl.sv | 148 ++++++++++++++
 tb/tb_xalu_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/xalu_ctrl.sv
// Multiply/divide sequencer for the MIPS XALU: latches operands, holds busy for a
// fixed latency, commits to HI/LO and serves MFHI/MFLO through rdata.
`timescale 1ns/1ps
module xalu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_sel,
    input  logic        use_xalu_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] ra_q;
    logic [31:0] rb_q;
    logic        sgn_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] prod_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] div_q_s;
    logic [31:0] div_r_s;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Result datapath: one 64-bit multiplier on extended operands, and a
    // magnitude divider whose signs are restored afterwards (wraps 0x80000000/-1).
    always_comb begin
        a_ext_s = sgn_q ? {{32{ra_q[31]}}, ra_q} : {32'd0, ra_q};
        b_ext_s = sgn_q ? {{32{rb_q[31]}}, rb_q} : {32'd0, rb_q};
        prod_s  = a_ext_s * b_ext_s;
        a_neg_s = sgn_q & ra_q[31];
        b_neg_s = sgn_q & rb_q[31];
        a_mag_s = neg_if(a_neg_s, ra_q);
        b_mag_s = neg_if(b_neg_s, rb_q);
        if (b_mag_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = a_mag_s / b_mag_s;
            r_mag_s = a_mag_s % b_mag_s;
        end
        div_q_s = neg_if(a_neg_s ^ b_neg_s, q_mag_s);
        div_r_s = neg_if(a_neg_s, r_mag_s);
    end

    // Sequencer: accepts work only in IDLE, counts down, commits on the last edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ra_q    <= 32'd0;
            rb_q    <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                ra_q    <= a;
                                rb_q    <= b;
                                sgn_q   <= (op == OP_MULT);
                                cnt_q   <= MULT_CNT;
                                state_q <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                ra_q    <= a;
                                rb_q    <= b;
                                sgn_q   <= (op == OP_DIV);
                                cnt_q   <= DIV_CNT;
                                state_q <= ST_DIV;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        hi_q    <= prod_s[63:32];
                        lo_q    <= prod_s[31:0];
                        state_q <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        // A zero divisor leaves HI/LO untouched.
                        if (rb_q != 32'd0) begin
                            hi_q <= div_r_s;
                            lo_q <= div_q_s;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign stall_req = use_xalu_d & (busy | (start & (op >= OP_MULT) & (op <= OP_DIVU)));
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rdata     = hi_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_xalu_ctrl.sv
// Self-checking bench for xalu_ctrl: a transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed literals.
`timescale 1ns/1ps
module tb_xalu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_sel = 1'b0;
    logic        use_xalu_d = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    xalu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .a(a), .b(b),
        .hi_sel(hi_sel), .use_xalu_d(use_xalu_d), .busy(busy),
        .stall_req(stall_req), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an operation is a countdown plus a precomputed result.
    int              m_left = 0;
    logic [31:0]     m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit              m_pwrite = 1'b0;
    longint          s_a, s_b, s_p, s_q, s_r;
    longint unsigned u_a, u_b, u_p;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_pwrite = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pwrite) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            s_a = $signed(a); s_b = $signed(b); u_a = a; u_b = b;
            case (op)
                3'd1: begin s_p = s_a * s_b; m_phi = s_p[63:32]; m_plo = s_p[31:0]; m_pwrite = 1'b1; m_left = 5; end
                3'd2: begin u_p = u_a * u_b; m_phi = u_p[63:32]; m_plo = u_p[31:0]; m_pwrite = 1'b1; m_left = 5; end
                3'd3: begin
                    m_pwrite = (b != 32'd0);
                    if (m_pwrite) begin s_q = s_a / s_b; s_r = s_a % s_b; m_plo = s_q[31:0]; m_phi = s_r[31:0]; end
                    m_left = 10;
                end
                3'd4: begin
                    m_pwrite = (b != 32'd0);
                    if (m_pwrite) begin m_plo = 32'(u_a / u_b); m_phi = 32'(u_a % u_b); end
                    m_left = 10;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("stall_req", {31'd0, stall_req},
                  {31'd0, use_xalu_d && (m_left > 0 || (start && op >= 3'd1 && op <= 3'd4))});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("rdata", rdata, hi_sel ? m_hi : m_lo);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        step(1);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    endtask

    // Counts busy cycles from the current point; returns at the first idle negedge.
    task automatic wait_idle(output int cycles);
        bit done;
        cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else cycles++;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
    endtask

    int c;

    initial begin
        step(1);
        chk_en = 1'b1;
        step(2);
        @(negedge clk); #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(c);
        check("mult_cycles", c, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        step(1);

        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle(c);
        check("multu_cycles", c, 32'd5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        step(1);
        hi_sel = 1'b1;
        issue(3'd5, 32'h12345678, 32'd0);
        @(negedge clk); #1;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_rdata", rdata, 32'h12345678);
        hi_sel = 1'b0;
        step(1);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(c);
        check("div_cycles", c, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        step(1);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(c);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        step(1);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(c);
        check("divov_lo", lo, 32'h80000000);
        check("divov_hi", hi, 32'd0);
        step(1);
        issue(3'd4, 32'd5, 32'd0);
        wait_idle(c);
        check("div0_cycles", c, 32'd10);
        check("div0_lo", lo, 32'h80000000);
        check("div0_hi", hi, 32'd0);
        step(1);

        use_xalu_d = 1'b1;
        issue(3'd1, 32'd3, 32'd4);
        step(1);
        op = 3'd6; a = 32'hDEADBEEF; start = 1'b1;
        step(1);
        start = 1'b0; op = 3'd0;
        @(negedge clk); #1;
        check("busy_mtlo_lo", lo, 32'h80000000);
        check("busy_stall", {31'd0, stall_req}, 32'd1);
        use_xalu_d = 1'b0;
        @(negedge clk); #1;
        check("nouse_stall", {31'd0, stall_req}, 32'd0);
        wait_idle(c);
        check("ign_lo", lo, 32'd12);
        check("ign_hi", hi, 32'd0);
        #1;

        issue(3'd2, 32'd6, 32'd7);
        wait_idle(c);
        check("b2b_lo1", lo, 32'd42);
        #1;
        op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        wait_idle(c);
        check("b2b_cycles", c, 32'd5);
        check("b2b_lo2", lo, 32'd300);
        step(1);

        issue(3'd3, 32'd100, 32'd7);
        step(3);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_lo", lo, 32'd0);
        step(1);
        reset = 1'b1;
        step(15);
        check("post_abort_lo", lo, 32'd0);
        check("post_abort_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
